// File: rtl/jtag_tap_pkg.sv
// Shared definitions for the oversampled JTAG TAP controller.
//   tap_state_e      : the sixteen IEEE 1149.1 TAP controller states
//   tap_next_state() : TMS-driven state transition, applied on each TCK rise
//   *_DEFAULT        : default IDCODE value and instruction opcodes
package jtag_tap_pkg;

    typedef enum logic [3:0] {
        TAP_TLR       = 4'd0,
        TAP_RTI       = 4'd1,
        TAP_SEL_DR    = 4'd2,
        TAP_CAP_DR    = 4'd3,
        TAP_SHIFT_DR  = 4'd4,
        TAP_EXIT1_DR  = 4'd5,
        TAP_PAUSE_DR  = 4'd6,
        TAP_EXIT2_DR  = 4'd7,
        TAP_UPD_DR    = 4'd8,
        TAP_SEL_IR    = 4'd9,
        TAP_CAP_IR    = 4'd10,
        TAP_SHIFT_IR  = 4'd11,
        TAP_EXIT1_IR  = 4'd12,
        TAP_PAUSE_IR  = 4'd13,
        TAP_EXIT2_IR  = 4'd14,
        TAP_UPD_IR    = 4'd15
    } tap_state_e;

    localparam logic [31:0] IDCODE_DEFAULT    = 32'h0000_0001;
    localparam logic [4:0]  IR_IDCODE_DEFAULT = 5'h01;
    localparam logic [4:0]  IR_USER_DEFAULT   = 5'h10;

    function automatic tap_state_e tap_next_state(input tap_state_e s, input logic tms);
        tap_state_e n;
        case (s)
            TAP_TLR:      n = tms ? TAP_TLR      : TAP_RTI;
            TAP_RTI:      n = tms ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_DR:   n = tms ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:   n = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR: n = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_EXIT1_DR: n = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
            TAP_PAUSE_DR: n = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            TAP_EXIT2_DR: n = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
            TAP_UPD_DR:   n = tms ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_IR:   n = tms ? TAP_TLR      : TAP_CAP_IR;
            TAP_CAP_IR:   n = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR: n = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_EXIT1_IR: n = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
            TAP_PAUSE_IR: n = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR: n = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
            TAP_UPD_IR:   n = tms ? TAP_SEL_DR   : TAP_RTI;
            default:      n = TAP_TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// TCK edge detector and TAP state register.
// TCK is treated as data oversampled by clk_i; a rise or fall is flagged for
// the single clk_i cycle in which the new TCK level is first seen.
// Ports:
//   clk_i, rst_i   : system clock, synchronous active-high reset
//   i_trst         : TAP reset request (forces Test-Logic-Reset)
//   i_tck, i_tms   : sampled JTAG pins
//   o_state        : current TAP state (also serves as debug view)
//   o_state_next   : state the TAP will hold after this clk_i cycle
//   o_rise, o_fall : one-cycle TCK edge strobes (mutually exclusive)
module jtag_tap_fsm
    import jtag_tap_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       i_trst,
    input  logic       i_tck,
    input  logic       i_tms,
    output tap_state_e o_state,
    output tap_state_e o_state_next,
    output logic       o_rise,
    output logic       o_fall
);

    logic       r_tck_q;
    tap_state_e r_state;
    tap_state_e w_state_next;

    assign o_rise = i_tck & ~r_tck_q;
    assign o_fall = ~i_tck & r_tck_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || i_trst) begin
            r_tck_q <= 1'b0;
            r_state <= TAP_TLR;
        end else begin
            r_tck_q <= i_tck;
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (o_rise) begin
            w_state_next = tap_next_state(r_state, i_tms);
        end
    end

    assign o_state      = r_state;
    assign o_state_next = w_state_next;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// Oversampled IEEE 1149.1 TAP controller with IDCODE, BYPASS and one USER
// data register. All JTAG pins live in the clk_i domain; every output is a
// register updated one clk_i cycle after the TCK edge that causes it.
// Ports:
//   clk_i, rst_i                     : system clock, synchronous active-high reset
//   jtag_tck_i/tms_i/tdi_i/trst_ni   : JTAG pins (TCK sampled as data)
//   jtag_tdo_o, jtag_tdo_oe_o        : TDO and its valid (Shift-IR/Shift-DR)
//   ir_o                             : current instruction
//   dr_capture_i                     : USER value loaded in Capture-DR
//   dr_update_o, dr_update_data_o    : USER update strobe and held data
// Build option:
//   JTAG_TAP_TRST_EN : when defined, jtag_trst_ni low resets the TAP (all
//                      but dr_update_data_o); otherwise jtag_trst_ni is ignored.
module jtag_tap_ctrl
    import jtag_tap_pkg::*;
#(
    parameter int unsigned        IrWidth     = 5,
    parameter int unsigned        DrWidth     = 32,
    parameter logic [31:0]        IdcodeValue = IDCODE_DEFAULT,
    parameter logic [IrWidth-1:0] IrIdcode    = IrWidth'(IR_IDCODE_DEFAULT),
    parameter logic [IrWidth-1:0] IrUser      = IrWidth'(IR_USER_DEFAULT)
)(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               jtag_tck_i,
    input  logic               jtag_tms_i,
    input  logic               jtag_tdi_i,
    input  logic               jtag_trst_ni,
    output logic               jtag_tdo_o,
    output logic               jtag_tdo_oe_o,
    output logic [IrWidth-1:0] ir_o,
    input  logic [DrWidth-1:0] dr_capture_i,
    output logic               dr_update_o,
    output logic [DrWidth-1:0] dr_update_data_o
);

    logic               w_trst;
    tap_state_e         w_state;
    tap_state_e         w_state_next;
    logic               w_rise;
    logic               w_fall;
    logic               w_sel_idcode;
    logic               w_sel_user;
    logic               w_dr_lsb;

    logic [IrWidth-1:0] r_ir_sr;
    logic [IrWidth-1:0] r_ir;
    logic [31:0]        r_idcode_sr;
    logic               r_bypass;
    logic [DrWidth-1:0] r_usr_sr;
    logic               r_tdo;
    logic               r_tdo_oe;
    logic               r_dr_update;
    logic [DrWidth-1:0] r_dr_update_data;

`ifdef JTAG_TAP_TRST_EN
    assign w_trst = ~jtag_trst_ni;
`else
    logic w_unused_trst;
    assign w_unused_trst = jtag_trst_ni;
    assign w_trst        = 1'b0;
`endif

    jtag_tap_fsm u_fsm (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .i_trst       (w_trst),
        .i_tck        (jtag_tck_i),
        .i_tms        (jtag_tms_i),
        .o_state      (w_state),
        .o_state_next (w_state_next),
        .o_rise       (w_rise),
        .o_fall       (w_fall)
    );

    // Any opcode other than IDCODE or USER selects the 1-bit bypass register.
    assign w_sel_idcode = (r_ir == IrIdcode);
    assign w_sel_user   = (r_ir == IrUser) && !w_sel_idcode;
    assign w_dr_lsb     = w_sel_idcode ? r_idcode_sr[0] :
                          w_sel_user   ? r_usr_sr[0]    : r_bypass;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ir_sr          <= '0;
            r_ir             <= IrIdcode;
            r_idcode_sr      <= '0;
            r_bypass         <= 1'b0;
            r_usr_sr         <= '0;
            r_tdo            <= 1'b0;
            r_tdo_oe         <= 1'b0;
            r_dr_update      <= 1'b0;
            r_dr_update_data <= '0;
        end else if (w_trst) begin
            // TAP reset leaves the last delivered USER value in place.
            r_ir_sr     <= '0;
            r_ir        <= IrIdcode;
            r_idcode_sr <= '0;
            r_bypass    <= 1'b0;
            r_usr_sr    <= '0;
            r_tdo       <= 1'b0;
            r_tdo_oe    <= 1'b0;
            r_dr_update <= 1'b0;
        end else begin
            r_dr_update <= 1'b0;
            if (w_rise) begin
                // Actions belong to the state being left on this rise.
                case (w_state)
                    TAP_CAP_IR:   r_ir_sr <= IrWidth'(2'b01);
                    TAP_SHIFT_IR: r_ir_sr <= {jtag_tdi_i, r_ir_sr[IrWidth-1:1]};
                    TAP_UPD_IR:   r_ir    <= r_ir_sr;
                    TAP_CAP_DR: begin
                        if (w_sel_idcode)    r_idcode_sr <= IdcodeValue;
                        else if (w_sel_user) r_usr_sr    <= dr_capture_i;
                        else                 r_bypass    <= 1'b0;
                    end
                    TAP_SHIFT_DR: begin
                        if (w_sel_idcode)
                            r_idcode_sr <= {jtag_tdi_i, r_idcode_sr[31:1]};
                        else if (w_sel_user)
                            // Written as shift/OR so DrWidth == 1 stays legal.
                            r_usr_sr <= (DrWidth'(jtag_tdi_i) << (DrWidth - 1)) | (r_usr_sr >> 1);
                        else
                            r_bypass <= jtag_tdi_i;
                    end
                    TAP_UPD_DR: begin
                        if (w_sel_user) begin
                            r_dr_update_data <= r_usr_sr;
                            r_dr_update      <= 1'b1;
                        end
                    end
                    default: ;
                endcase
                if (w_state_next == TAP_TLR) begin
                    r_ir <= IrIdcode;
                end
            end
            if (w_fall) begin
                if (w_state == TAP_SHIFT_IR) begin
                    r_tdo    <= r_ir_sr[0];
                    r_tdo_oe <= 1'b1;
                end else if (w_state == TAP_SHIFT_DR) begin
                    r_tdo    <= w_dr_lsb;
                    r_tdo_oe <= 1'b1;
                end else begin
                    r_tdo_oe <= 1'b0;
                end
            end
        end
    end

    assign jtag_tdo_o       = r_tdo;
    assign jtag_tdo_oe_o    = r_tdo_oe;
    assign ir_o             = r_ir;
    assign dr_update_o      = r_dr_update;
    assign dr_update_data_o = r_dr_update_data;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Bench for jtag_tap_ctrl. The reference model works at the scan level: a
// data-register scan is a bit FIFO preloaded with the captured value (LSB
// first); each shift pops the bit seen on TDO and pushes TDI. What remains in
// the FIFO after the scan is the register content delivered on update.
module tb_jtag_tap_ctrl;

    localparam int          IR_W   = 5;
    localparam int          DR_W   = 8;
    localparam logic [31:0] IDCODE = 32'h1BA0_0477;
    localparam logic [4:0]  IR_IDC = 5'h01;
    localparam logic [4:0]  IR_USR = 5'h10;
    localparam logic [4:0]  IR_BYP = 5'h1F;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            tck = 1'b0;
    logic            tms = 1'b1;
    logic            tdi = 1'b0;
    logic            trst_n = 1'b1;
    logic            tdo;
    logic            tdo_oe;
    logic [IR_W-1:0] ir;
    logic [DR_W-1:0] dr_cap = '0;
    logic            dr_upd;
    logic [DR_W-1:0] dr_upd_data;

    int              n_total = 0;
    int              n_bad   = 0;
    int              upd_cnt = 0;

    // model state
    logic [IR_W-1:0] m_ir       = IR_IDC;
    int              m_upd_cnt  = 0;
    logic [DR_W-1:0] m_upd_data = '0;

    jtag_tap_ctrl #(
        .IrWidth     (IR_W),
        .DrWidth     (DR_W),
        .IdcodeValue (IDCODE),
        .IrIdcode    (IR_IDC),
        .IrUser      (IR_USR)
    ) u_dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .jtag_tck_i       (tck),
        .jtag_tms_i       (tms),
        .jtag_tdi_i       (tdi),
        .jtag_trst_ni     (trst_n),
        .jtag_tdo_o       (tdo),
        .jtag_tdo_oe_o    (tdo_oe),
        .ir_o             (ir),
        .dr_capture_i     (dr_cap),
        .dr_update_o      (dr_upd),
        .dr_update_data_o (dr_upd_data)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // counts clk cycles with the update strobe high
    always @(negedge clk) if (dr_upd === 1'b1) upd_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One TCK period; returns TDO/OE as seen just before the rise.
    task automatic tck_pulse(input logic t_ms, input logic t_di, output logic o_tdo, output logic o_oe);
        int k;
        o_tdo = tdo;
        o_oe  = tdo_oe;
        tms = t_ms;
        tdi = t_di;
        k = $urandom_range(1, 2);
        tck = 1'b1;
        repeat (k) @(negedge clk);
        tck = 1'b0;
        k = $urandom_range(1, 2);
        repeat (k) @(negedge clk);
    endtask

    task automatic pulses(input logic t_ms, input int n);
        logic a, b;
        for (int i = 0; i < n; i++) tck_pulse(t_ms, 1'b0, a, b);
    endtask

    // RTI -> IR scan of `extra` random bits then `code` -> Update-IR -> RTI
    task automatic scan_ir(input logic [IR_W-1:0] code, input int extra, output logic [63:0] obs);
        logic bit_q[$];
        logic [63:0] exp_out;
        logic [63:0] din;
        int   n, oe_cnt;
        logic t, o;
        bit_q = {};
        bit_q.push_back(1'b1);
        bit_q.push_back(1'b0);
        for (int i = 2; i < IR_W; i++) bit_q.push_back(1'b0);
        din = {$urandom(), $urandom()};
        for (int i = 0; i < IR_W; i++) din[extra + i] = code[i];
        n = extra + IR_W;
        obs = '0; exp_out = '0; oe_cnt = 0;
        tck_pulse(1'b1, 1'b0, t, o); oe_cnt += int'(o);
        tck_pulse(1'b1, 1'b0, t, o); oe_cnt += int'(o);
        tck_pulse(1'b0, 1'b0, t, o); oe_cnt += int'(o);
        tck_pulse(1'b0, 1'b0, t, o); oe_cnt += int'(o);
        for (int i = 0; i < n; i++) begin
            tck_pulse(i == n - 1, din[i], t, o);
            obs[i] = t;
            oe_cnt += int'(o);
            exp_out[i] = bit_q.pop_front();
            bit_q.push_back(din[i]);
        end
        tck_pulse(1'b1, 1'b0, t, o); oe_cnt += int'(o);
        tck_pulse(1'b0, 1'b0, t, o); oe_cnt += int'(o);
        for (int i = 0; i < n; i++) if (i >= 64) obs[0] = 1'bx;
        chk("ir_tdo", obs, exp_out);
        chk("ir_oe_cnt", 64'(oe_cnt), 64'(n));
        for (int i = 0; i < IR_W; i++) m_ir[i] = bit_q[i];
        chk("ir_after_update", 64'(ir), 64'(m_ir));
    endtask

    // RTI -> DR scan of n bits -> Update-DR -> RTI.
    // trst_at >= 0 pulses jtag_trst_ni low before that shift (build without TRST only).
    task automatic scan_dr(input int n, input logic [63:0] din, input int trst_at, output logic [63:0] obs);
        logic bit_q[$];
        logic [63:0] exp_out;
        logic [31:0] v;
        logic [DR_W-1:0] exp_d;
        int   w, oe_cnt;
        logic t, o;
        if (m_ir == IR_IDC)      begin w = 32;   v = IDCODE;     end
        else if (m_ir == IR_USR) begin w = DR_W; v = 32'(dr_cap); end
        else                     begin w = 1;    v = '0;         end
        bit_q = {};
        for (int i = 0; i < w; i++) bit_q.push_back(v[i]);
        obs = '0; exp_out = '0; oe_cnt = 0;
        tck_pulse(1'b1, 1'b0, t, o); oe_cnt += int'(o);
        tck_pulse(1'b0, 1'b0, t, o); oe_cnt += int'(o);
        tck_pulse(1'b0, 1'b0, t, o); oe_cnt += int'(o);
        for (int i = 0; i < n; i++) begin
            if (i == trst_at) begin
                trst_n = 1'b0;
                repeat (2) @(negedge clk);
                trst_n = 1'b1;
            end
            tck_pulse(i == n - 1, din[i], t, o);
            obs[i] = t;
            oe_cnt += int'(o);
            exp_out[i] = bit_q.pop_front();
            bit_q.push_back(din[i]);
        end
        tck_pulse(1'b1, 1'b0, t, o); oe_cnt += int'(o);
        tck_pulse(1'b0, 1'b0, t, o); oe_cnt += int'(o);
        chk("dr_tdo", obs, exp_out);
        chk("dr_oe_cnt", 64'(oe_cnt), 64'(n));
        if (m_ir == IR_USR) begin
            for (int j = 0; j < DR_W; j++) exp_d[j] = bit_q[j];
            m_upd_data = exp_d;
            m_upd_cnt++;
        end
        chk("upd_cnt", 64'(upd_cnt), 64'(m_upd_cnt));
        chk("upd_data", 64'(dr_upd_data), 64'(m_upd_data));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ir"}, 64'(ir), 64'(IR_IDC));
        chk({tag, "_tdo"}, 64'(tdo), 64'd0);
        chk({tag, "_oe"}, 64'(tdo_oe), 64'd0);
        chk({tag, "_upd"}, 64'(dr_upd), 64'd0);
        chk({tag, "_upd_data"}, 64'(dr_upd_data), 64'd0);
    endtask

    initial begin
        logic [63:0] obs;
        logic [63:0] din;
        logic [IR_W-1:0] code;
        // reset
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("reset");

        // 1: BYPASS, then Shift-DR, then five TMS=1 rises -> Test-Logic-Reset
        pulses(1'b0, 1);
        scan_ir(IR_BYP, 0, obs);
        pulses(1'b1, 1); pulses(1'b0, 2);
        pulses(1'b1, 5);
        chk("tlr_ir", 64'(ir), 64'(IR_IDC));
        chk("tlr_oe", 64'(tdo_oe), 64'd0);
        m_ir = IR_IDC;
        pulses(1'b0, 1);

        // 2: IDCODE scan
        scan_dr(32, {$urandom(), $urandom()}, -1, obs);
        chk("idcode_value", obs[31:0], 64'(IDCODE));

        // 3: IR capture pattern and BYPASS load
        scan_ir(5'h1F, 0, obs);
        chk("ir_capture_bits", 64'(obs[1:0]), 64'(2'b01));
        chk("ir_bypass", 64'(ir), 64'h1F);

        // 4: bypass delay
        scan_dr(4, 64'b1101, -1, obs);
        chk("bypass_tdo", 64'(obs[3:0]), 64'(4'b1010));

        // 5: USER capture/update
        scan_ir(IR_USR, 0, obs);
        dr_cap = 8'h3C;
        scan_dr(8, 64'hA5, -1, obs);
        chk("user_capture", 64'(obs[7:0]), 64'h3C);
        chk("user_update", 64'(dr_upd_data), 64'hA5);

        // 6: TAP reset pin mid-shift
`ifdef JTAG_TAP_TRST_EN
        dr_cap = 8'h5A;
        pulses(1'b1, 1); pulses(1'b0, 2);
        pulses(1'b0, 3);
        chk("trst_pre_oe", 64'(tdo_oe), 64'd1);
        trst_n = 1'b0;
        @(negedge clk);
        chk("trst_ir", 64'(ir), 64'(IR_IDC));
        chk("trst_oe", 64'(tdo_oe), 64'd0);
        chk("trst_upd_data_held", 64'(dr_upd_data), 64'(m_upd_data));
        trst_n = 1'b1;
        m_ir = IR_IDC;
        pulses(1'b0, 1);
        scan_dr(32, {$urandom(), $urandom()}, -1, obs);
`else
        dr_cap = 8'h5A;
        scan_dr(8, 64'h69, 3, obs);
        chk("trst_ignored_ir", 64'(ir), 64'(IR_USR));
`endif

        // randomized operations
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    case ($urandom_range(0, 3))
                        0: code = IR_IDC;
                        1: code = IR_USR;
                        2: code = IR_BYP;
                        default: code = IR_W'($urandom());
                    endcase
                    scan_ir(code, $urandom_range(0, 4), obs);
                end
                3, 4, 5, 6, 7: begin
                    dr_cap = DR_W'($urandom());
                    din = {$urandom(), $urandom()};
                    scan_dr($urandom_range(1, 64), din, -1, obs);
                end
                8: begin
                    pulses(1'b1, $urandom_range(5, 7));
                    m_ir = IR_IDC;
                    pulses(1'b0, 1);
                    chk("tms_reset_ir", 64'(ir), 64'(m_ir));
                end
                default: begin
                    pulses(1'b0, $urandom_range(1, 4));
                    chk("idle_ir", 64'(ir), 64'(m_ir));
                end
            endcase
        end

        // reset in the middle of a USER shift
        scan_ir(IR_USR, 0, obs);
        dr_cap = 8'hC3;
        pulses(1'b1, 1); pulses(1'b0, 2); pulses(1'b0, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("midshift_reset");
        m_ir = IR_IDC;
        m_upd_data = '0;
        pulses(1'b0, 1);
        scan_dr(32, {$urandom(), $urandom()}, -1, obs);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
